// File: rtl/bram_pkg.sv
`default_nettype none
// ============================================================================
// bram_pkg : shared types and constants for the scrubbed TDP block RAM
// Revision : 1.0
// ============================================================================
package bram_pkg;

  typedef enum logic [1:0] {
    RD_FIRST  = 2'd0,
    WR_FIRST  = 2'd1,
    NO_CHANGE = 2'd2
  } rd_mode_e;

  typedef enum logic [0:0] {
    S_SCRUB = 1'b0,
    S_DONE  = 1'b1
  } scrub_state_e;

  localparam logic [31:0] RV_NOP     = 32'h0000_0013;
  localparam logic [31:0] SCRUB_FILL = 32'hDEAD_BEEF;

endpackage
`default_nettype wire

// File: rtl/tdp_bram_scrub_if.sv
`default_nettype none
// ============================================================================
// tdp_bram_scrub_if : dual-port memory bus plus status/tap signals
// Revision : 1.0
// ============================================================================
interface tdp_bram_scrub_if #(
  parameter int NUM_COL    = 4,
  parameter int COL_WIDTH  = 8,
  parameter int ADDR_WIDTH = 13
);
  localparam int DATA_WIDTH = NUM_COL * COL_WIDTH;

  logic                  enaA;
  logic [NUM_COL-1:0]    weA;
  logic [ADDR_WIDTH-1:0] addrA;
  logic [DATA_WIDTH-1:0] dinA;
  logic [DATA_WIDTH-1:0] doutA;
  logic                  rvalidA;

  logic                  enaB;
  logic [NUM_COL-1:0]    weB;
  logic [ADDR_WIDTH-1:0] addrB;
  logic [DATA_WIDTH-1:0] dinB;
  logic [DATA_WIDTH-1:0] doutB;
  logic                  rvalidB;

  logic                  ready;
  logic                  collision;
  logic [DATA_WIDTH-1:0] tap_o;

  modport master (
    output enaA, weA, addrA, dinA, enaB, weB, addrB, dinB,
    input  doutA, rvalidA, doutB, rvalidB, ready, collision, tap_o
  );

  modport slave (
    input  enaA, weA, addrA, dinA, enaB, weB, addrB, dinB,
    output doutA, rvalidA, doutB, rvalidB, ready, collision, tap_o
  );

endinterface
`default_nettype wire

// File: rtl/bram_scrub_seq.sv
`default_nettype none
// ============================================================================
// bram_scrub_seq : post-reset fill sequencer; owns the port B write path
// Revision : 1.0
// ============================================================================
module bram_scrub_seq
  import bram_pkg::*;
#(
  parameter int                           NUM_COL    = 4,
  parameter int                           COL_WIDTH  = 8,
  parameter int                           ADDR_WIDTH = 13,
  parameter bit                           SCRUB_EN   = 1'b1,
  parameter logic [NUM_COL*COL_WIDTH-1:0] INIT_WORD  = SCRUB_FILL
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_COL-1:0]             weB_i,
  input  logic [ADDR_WIDTH-1:0]          addrB_i,
  input  logic [NUM_COL*COL_WIDTH-1:0]   dinB_i,
  output logic [NUM_COL-1:0]             weB_o,
  output logic [ADDR_WIDTH-1:0]          addrB_o,
  output logic [NUM_COL*COL_WIDTH-1:0]   dinB_o,
  output logic                           ready_o
);

  scrub_state_e          state_q;
  logic [ADDR_WIDTH-1:0] count_q;
  logic                  ready_q;
  logic                  w_scrub;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_SCRUB;
      count_q <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        S_SCRUB: begin
          if (!SCRUB_EN || (count_q == {ADDR_WIDTH{1'b1}})) begin
            state_q <= S_DONE;
            ready_q <= 1'b1;
          end else begin
            count_q <= count_q + ADDR_WIDTH'(1);
          end
        end
        default: ready_q <= 1'b1;
      endcase
    end
  end

  // Scrub steals port B for the whole fill; user access is blocked by ready anyway
  assign w_scrub = SCRUB_EN && (state_q == S_SCRUB) && !reset;

  assign weB_o   = w_scrub ? {NUM_COL{1'b1}} : weB_i;
  assign addrB_o = w_scrub ? count_q         : addrB_i;
  assign dinB_o  = w_scrub ? INIT_WORD       : dinB_i;
  assign ready_o = ready_q;

endmodule
`default_nettype wire

// File: rtl/tdp_bram_scrub.sv
`default_nettype none
// ============================================================================
// tdp_bram_scrub : true-dual-port byte-write RAM with hardware scrub and tap
// Revision : 1.0
// ============================================================================
module tdp_bram_scrub
  import bram_pkg::*;
#(
  parameter int                           NUM_COL    = 4,
  parameter int                           COL_WIDTH  = 8,
  parameter int                           ADDR_WIDTH = 13,
  parameter rd_mode_e                     RD_MODE_A  = RD_FIRST,
  parameter rd_mode_e                     RD_MODE_B  = RD_FIRST,
  parameter bit                           OUT_REG    = 1'b0,
  parameter bit                           SCRUB_EN   = 1'b1,
  parameter logic [NUM_COL*COL_WIDTH-1:0] INIT_WORD  = SCRUB_FILL,
  parameter logic [NUM_COL*COL_WIDTH-1:0] RST_DOUT   = RV_NOP,
  parameter logic [ADDR_WIDTH-1:0]        TAP_ADDR   = 'h3FF
) (
  input  logic            clk,
  input  logic            reset,
  tdp_bram_scrub_if.slave bus
);

  localparam int DATA_WIDTH = NUM_COL * COL_WIDTH;
  localparam int DEPTH      = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  w_ready;
  logic                  w_accA, w_accB, w_matchAB;
  logic [NUM_COL-1:0]    w_weA, w_weB_req, w_weB;
  logic [ADDR_WIDTH-1:0] w_addrB;
  logic [DATA_WIDTH-1:0] w_dinB;
  logic [DATA_WIDTH-1:0] w_oldA, w_oldB, w_mrgA, w_mrgB;

  logic [DATA_WIDTH-1:0] rdA_q, rdB_q, tap_q;
  logic                  rvA_q, rvB_q, collision_q;

  // Reset gates acceptance so a stale ready cannot let a write through
  assign w_accA    = bus.enaA && w_ready && !reset;
  assign w_accB    = bus.enaB && w_ready && !reset;
  assign w_matchAB = w_accA && w_accB && (bus.addrA == bus.addrB);
  assign w_weB_req = w_accB ? bus.weB : '0;
  assign w_weA     = w_accA ? (bus.weA & ~(w_matchAB ? bus.weB : '0)) : '0;

  bram_scrub_seq #(
    .NUM_COL    (NUM_COL),
    .COL_WIDTH  (COL_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .SCRUB_EN   (SCRUB_EN),
    .INIT_WORD  (INIT_WORD)
  ) u_seq (
    .clk     (clk),
    .reset   (reset),
    .weB_i   (w_weB_req),
    .addrB_i (bus.addrB),
    .dinB_i  (bus.dinB),
    .weB_o   (w_weB),
    .addrB_o (w_addrB),
    .dinB_o  (w_dinB),
    .ready_o (w_ready)
  );

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_COL; c++) begin
      if (w_weA[c]) mem[bus.addrA][c*COL_WIDTH +: COL_WIDTH] <= bus.dinA[c*COL_WIDTH +: COL_WIDTH];
      if (w_weB[c]) mem[w_addrB][c*COL_WIDTH +: COL_WIDTH]   <= w_dinB[c*COL_WIDTH +: COL_WIDTH];
    end
  end

  assign w_oldA = mem[bus.addrA];
  assign w_oldB = mem[bus.addrB];

  always_comb begin
    w_mrgA = w_oldA;
    w_mrgB = w_oldB;
    for (int c = 0; c < NUM_COL; c++) begin
      if (bus.weA[c]) w_mrgA[c*COL_WIDTH +: COL_WIDTH] = bus.dinA[c*COL_WIDTH +: COL_WIDTH];
      if (bus.weB[c]) w_mrgB[c*COL_WIDTH +: COL_WIDTH] = bus.dinB[c*COL_WIDTH +: COL_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdA_q       <= RST_DOUT;
      rdB_q       <= RST_DOUT;
      rvA_q       <= 1'b0;
      rvB_q       <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      rvA_q       <= 1'b0;
      rvB_q       <= 1'b0;
      collision_q <= w_matchAB && ((|bus.weA) || (|bus.weB));
      if (w_accA && (!(|bus.weA) || (RD_MODE_A != NO_CHANGE))) begin
        rdA_q <= ((|bus.weA) && (RD_MODE_A == WR_FIRST)) ? w_mrgA : w_oldA;
        rvA_q <= 1'b1;
      end
      if (w_accB && (!(|bus.weB) || (RD_MODE_B != NO_CHANGE))) begin
        rdB_q <= ((|bus.weB) && (RD_MODE_B == WR_FIRST)) ? w_mrgB : w_oldB;
        rvB_q <= 1'b1;
      end
    end
  end

  // Tap mirrors the merged write at TAP_ADDR; port B lanes win on overlap
  always_ff @(posedge clk) begin
    if (reset) begin
      tap_q <= INIT_WORD;
    end else begin
      for (int c = 0; c < NUM_COL; c++) begin
        if (w_weB[c] && (w_addrB == TAP_ADDR))
          tap_q[c*COL_WIDTH +: COL_WIDTH] <= w_dinB[c*COL_WIDTH +: COL_WIDTH];
        else if (w_weA[c] && (bus.addrA == TAP_ADDR))
          tap_q[c*COL_WIDTH +: COL_WIDTH] <= bus.dinA[c*COL_WIDTH +: COL_WIDTH];
      end
    end
  end

  generate
    if (OUT_REG) begin : g_out_reg
      logic [DATA_WIDTH-1:0] doutA_q, doutB_q;
      logic                  rvalidA_q, rvalidB_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          doutA_q   <= RST_DOUT;
          doutB_q   <= RST_DOUT;
          rvalidA_q <= 1'b0;
          rvalidB_q <= 1'b0;
        end else begin
          doutA_q   <= rdA_q;
          doutB_q   <= rdB_q;
          rvalidA_q <= rvA_q;
          rvalidB_q <= rvB_q;
        end
      end

      assign bus.doutA   = doutA_q;
      assign bus.doutB   = doutB_q;
      assign bus.rvalidA = rvalidA_q;
      assign bus.rvalidB = rvalidB_q;
    end else begin : g_no_out_reg
      assign bus.doutA   = rdA_q;
      assign bus.doutB   = rdB_q;
      assign bus.rvalidA = rvA_q;
      assign bus.rvalidB = rvB_q;
    end
  endgenerate

  assign bus.ready     = w_ready;
  assign bus.collision = collision_q;
  assign bus.tap_o     = tap_q;

endmodule
`default_nettype wire

// File: tb/tb_tdp_bram_scrub.sv
`default_nettype none
// ============================================================================
// tb_tdp_bram_scrub : directed bench over three configurations of the RAM
// Revision : 1.0
// ============================================================================
module tb_tdp_bram_scrub;
  import bram_pkg::*;

  localparam int            AW  = 4;
  localparam logic [AW-1:0] TAP = 4'hA;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  logic          enaA, enaB;
  logic [3:0]    weA, weB;
  logic [AW-1:0] addrA, addrB;
  logic [31:0]   dinA, dinB;

  always #5 clk = ~clk;

  tdp_bram_scrub_if #(.NUM_COL(4), .COL_WIDTH(8), .ADDR_WIDTH(AW)) i0 ();
  tdp_bram_scrub_if #(.NUM_COL(4), .COL_WIDTH(8), .ADDR_WIDTH(AW)) i1 ();
  tdp_bram_scrub_if #(.NUM_COL(4), .COL_WIDTH(8), .ADDR_WIDTH(AW)) i2 ();

  assign i0.enaA  = enaA;  assign i1.enaA  = enaA;  assign i2.enaA  = enaA;
  assign i0.weA   = weA;   assign i1.weA   = weA;   assign i2.weA   = weA;
  assign i0.addrA = addrA; assign i1.addrA = addrA; assign i2.addrA = addrA;
  assign i0.dinA  = dinA;  assign i1.dinA  = dinA;  assign i2.dinA  = dinA;
  assign i0.enaB  = enaB;  assign i1.enaB  = enaB;  assign i2.enaB  = enaB;
  assign i0.weB   = weB;   assign i1.weB   = weB;   assign i2.weB   = weB;
  assign i0.addrB = addrB; assign i1.addrB = addrB; assign i2.addrB = addrB;
  assign i0.dinB  = dinB;  assign i1.dinB  = dinB;  assign i2.dinB  = dinB;

  // d0: read-first both ports; d1: write-first on B; d2: no-change on B + output register
  tdp_bram_scrub #(.ADDR_WIDTH(AW), .TAP_ADDR(TAP), .RD_MODE_A(RD_FIRST), .RD_MODE_B(RD_FIRST),
                   .OUT_REG(1'b0)) d0 (.clk(clk), .reset(reset), .bus(i0));
  tdp_bram_scrub #(.ADDR_WIDTH(AW), .TAP_ADDR(TAP), .RD_MODE_A(RD_FIRST), .RD_MODE_B(WR_FIRST),
                   .OUT_REG(1'b0)) d1 (.clk(clk), .reset(reset), .bus(i1));
  tdp_bram_scrub #(.ADDR_WIDTH(AW), .TAP_ADDR(TAP), .RD_MODE_A(RD_FIRST), .RD_MODE_B(NO_CHANGE),
                   .OUT_REG(1'b1)) d2 (.clk(clk), .reset(reset), .bus(i2));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic ea, input logic [3:0] wa, input logic [AW-1:0] aa, input logic [31:0] da,
                     input logic eb, input logic [3:0] wb, input logic [AW-1:0] ab, input logic [31:0] db);
    enaA = ea; weA = wa; addrA = aa; dinA = da;
    enaB = eb; weB = wb; addrB = ab; dinB = db;
  endtask

  task automatic idle();
    drv(1'b0, 4'h0, 4'd0, 32'h0, 1'b0, 4'h0, 4'd0, 32'h0);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int cyc = 0;
    while (i0.ready !== 1'b1 && cyc < 40) begin
      step();
      cyc++;
    end
    chk(tag, 32'(cyc), 32'd16);
    chk({tag, "_d2"}, 32'(i2.ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    idle();
    repeat (3) step();
    chk("rst_doutA",  i0.doutA, 32'h0000_0013);
    chk("rst_doutB",  i0.doutB, 32'h0000_0013);
    chk("rst_rvalA",  32'(i0.rvalidA), 32'd0);
    chk("rst_ready",  32'(i0.ready), 32'd0);
    chk("rst_coll",   32'(i0.collision), 32'd0);
    chk("rst_tap",    i0.tap_o, 32'hDEAD_BEEF);
    chk("rst_doutA2", i2.doutA, 32'h0000_0013);

    // requests during scrub must be ignored, including this port B write
    drv(1'b1, 4'h0, 4'd3, 32'h0, 1'b1, 4'hF, 4'd4, 32'h5555_5555);
    reset = 1'b0;
    wait_ready("scrub_len");
    idle();
    chk("pre_ready_doutA", i0.doutA, 32'h0000_0013);
    chk("pre_ready_rvalA", 32'(i0.rvalidA), 32'd0);
    chk("pre_ready_doutB", i0.doutB, 32'h0000_0013);

    for (int a = 0; a < 16; a++) begin
      drv(1'b1, 4'h0, AW'(a), 32'h0, 1'b0, 4'h0, 4'd0, 32'h0);
      step();
      chk($sformatf("scrub_rd%0d", a), i0.doutA, 32'hDEAD_BEEF);
    end
    chk("rd_rvalA", 32'(i0.rvalidA), 32'd1);
    idle();
    step();
    chk("dis_hold", i0.doutA, 32'hDEAD_BEEF);
    chk("dis_rvalA", 32'(i0.rvalidA), 32'd0);

    // byte-lane write on B: read-first vs write-first vs no-change
    drv(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'b0101, 4'd5, 32'h1122_3344);
    step();
    chk("rdfirst_B", i0.doutB, 32'hDEAD_BEEF);
    chk("wrfirst_B", i1.doutB, 32'hDE22_BE44);
    chk("wr_rvalB",  32'(i0.rvalidB), 32'd1);
    drv(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'h0, 4'd5, 32'h0);
    step();
    chk("rdback_d0", i0.doutB, 32'hDE22_BE44);
    chk("rdback_d1", i1.doutB, 32'hDE22_BE44);
    chk("nochg_dout", i2.doutB, 32'h0000_0013);
    chk("nochg_rvalB", 32'(i2.rvalidB), 32'd0);
    idle();
    step();
    chk("nochg_rd", i2.doutB, 32'hDE22_BE44);
    chk("nochg_rd_rv", 32'(i2.rvalidB), 32'd1);

    // both ports write addr 7
    drv(1'b1, 4'hF, 4'd7, 32'hAAAA_AAAA, 1'b1, 4'b0011, 4'd7, 32'hBBBB_BBBB);
    step();
    chk("coll_pulse", 32'(i0.collision), 32'd1);
    chk("coll_old",   i0.doutA, 32'hDEAD_BEEF);
    drv(1'b1, 4'h0, 4'd7, 32'h0, 1'b0, 4'h0, 4'd0, 32'h0);
    step();
    chk("coll_clear", 32'(i0.collision), 32'd0);
    chk("dual_wr",    i0.doutA, 32'hAAAA_BBBB);
    // B writes while A reads the same word
    drv(1'b1, 4'h0, 4'd7, 32'h0, 1'b1, 4'b1000, 4'd7, 32'h7700_0000);
    step();
    chk("rw_old",  i0.doutA, 32'hAAAA_BBBB);
    chk("rw_coll", 32'(i0.collision), 32'd1);
    drv(1'b1, 4'h0, 4'd7, 32'h0, 1'b0, 4'h0, 4'd0, 32'h0);
    step();
    chk("rw_new",   i0.doutA, 32'h77AA_BBBB);
    chk("rw_coll0", 32'(i0.collision), 32'd0);

    // output-register pipeline on d2 port A
    drv(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'hF, 4'd1, 32'h0101_0101); step();
    drv(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'hF, 4'd2, 32'h0202_0202); step();
    drv(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'hF, 4'd3, 32'h0303_0303); step();
    drv(1'b1, 4'h0, 4'd1, 32'h0, 1'b0, 4'h0, 4'd0, 32'h0); step();
    chk("oreg_c1_rv", 32'(i2.rvalidA), 32'd0);
    drv(1'b1, 4'h0, 4'd2, 32'h0, 1'b0, 4'h0, 4'd0, 32'h0); step();
    chk("oreg_c2", i2.doutA, 32'h0101_0101);
    chk("oreg_c2_rv", 32'(i2.rvalidA), 32'd1);
    drv(1'b1, 4'h0, 4'd3, 32'h0, 1'b0, 4'h0, 4'd0, 32'h0); step();
    chk("oreg_c3", i2.doutA, 32'h0202_0202);
    idle(); step();
    chk("oreg_c4", i2.doutA, 32'h0303_0303);
    chk("oreg_c4_rv", 32'(i2.rvalidA), 32'd1);
    step();
    chk("oreg_c5_rv", 32'(i2.rvalidA), 32'd0);
    chk("oreg_c5_hold", i2.doutA, 32'h0303_0303);

    // tap word
    chk("tap_scrub", i0.tap_o, 32'hDEAD_BEEF);
    drv(1'b1, 4'hF, TAP, 32'h1234_5678, 1'b0, 4'h0, 4'd0, 32'h0); step();
    chk("tap_wr", i0.tap_o, 32'h1234_5678);
    drv(1'b1, 4'hF, 4'd9, 32'hCAFE_F00D, 1'b0, 4'h0, 4'd0, 32'h0); step();
    chk("tap_hold", i0.tap_o, 32'h1234_5678);

    // reset, partial scrub, reset again: full-length scrub restarts from 0
    idle();
    reset = 1'b1; step();
    chk("tap_rst", i0.tap_o, 32'hDEAD_BEEF);
    chk("rst2_ready", 32'(i0.ready), 32'd0);
    reset = 1'b0;
    repeat (5) step();
    reset = 1'b1; step();
    reset = 1'b0;
    wait_ready("rescrub_len");
    drv(1'b1, 4'h0, 4'd7, 32'h0, 1'b1, 4'h0, 4'd9, 32'h0); step();
    chk("rescrub_a7", i0.doutA, 32'hDEAD_BEEF);
    chk("rescrub_b9", i0.doutB, 32'hDEAD_BEEF);
    chk("rescrub_tap", i0.tap_o, 32'hDEAD_BEEF);
    idle(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
